channel_llr_loader: RTL

//  Write side of the channel LLR register. Accepts channel LLRs from the front end as
//  2^(p+1)-LLR chunks over a valid/ready handshake and assembles a full 2^n-LLR frame.

---
 rtl/channel_llr_loader_if.sv | 39 +++
 rtl/channel_llr_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/channel_llr_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : channel_llr_loader_if
// Description : Chunk stream from the channel front end into the LLR loader.
//               One chunk of LLRs per transfer over a valid/ready handshake,
//               with a last flag marking the final chunk of a frame.
// Ports       : llr_in        chunk payload, LLR i at bits [i*Q +: Q]
//               llr_in_valid  llr_in holds a valid chunk
//               llr_in_last   qualifies the final chunk of a frame
//               llr_in_ready  loader can accept a chunk this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface channel_llr_loader_if #(
  parameter int W = 24
) ();

  logic [W-1:0] llr_in;
  logic         llr_in_valid;
  logic         llr_in_last;
  logic         llr_in_ready;

  // Front end side: drives the chunk stream, observes ready.
  modport master (
    output llr_in,
    output llr_in_valid,
    output llr_in_last,
    input  llr_in_ready
  );

  // Loader side: consumes the chunk stream, drives ready.
  modport slave (
    input  llr_in,
    input  llr_in_valid,
    input  llr_in_last,
    output llr_in_ready
  );

endinterface
`default_nettype wire

// File: rtl/channel_llr_loader.sv
`default_nettype none
// ============================================================================
// Module      : channel_llr_loader
// Description : Write side of the channel LLR register. Assembles 2^N LLRs
//               from NCH chunks of 2^(P+1) LLRs each, presents the complete
//               frame with a one-cycle data_valid pulse, and holds it stable
//               until the decoder signals decoder_done.
// Parameters  : N  log2 code length (frame holds 2^N LLRs)
//               P  log2 parallelism (chunk holds 2^(P+1) LLRs), N >= P+1
//               Q  LLR bit width, two's complement
// Ports       : clk                    rising-edge clock
//               rst_n                  asynchronous reset, active low
//               llr_bus                chunk stream (slave side)
//               decoder_done           decoder finished with held frame
//               channel_register_data  frame, chunk k at bits [k*W +: W]
//               data_valid             pulse: frame complete and stable
//               frame_error            pulse: last/length mismatch
//               chunk_count            next chunk slot to be written
// Revision    : 1.0 - initial release
// ============================================================================
module channel_llr_loader #(
  parameter int N = 3,
  parameter int P = 1,
  parameter int Q = 6,
  localparam int W   = (2 ** (P + 1)) * Q,
  localparam int NCH = 2 ** (N - P - 1),
  localparam int CW  = ((N - P - 1) > 0) ? (N - P - 1) : 1
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  channel_llr_loader_if.slave           llr_bus,
  input  wire logic                     decoder_done,
  output logic [(2 ** N) * Q - 1:0]     channel_register_data,
  output logic                          data_valid,
  output logic                          frame_error,
  output logic [CW-1:0]                 chunk_count
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_VALID = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            chunk_count_q, chunk_count_d;
  logic                     frame_error_q, frame_error_d;
  logic [NCH*W-1:0]         frame_q;

  logic                     ready;
  logic                     accept;
  logic                     is_final;

  // Ready depends only on state so the front end never sees a
  // combinational path from its own valid back to ready.
  assign ready    = (state_q == S_LOAD);
  assign accept   = ready && llr_bus.llr_in_valid;
  // With a single chunk per frame the counter stays at 0 and every
  // chunk compares as final.
  assign is_final = (chunk_count_q == LAST_IDX);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      chunk_count_q <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      chunk_count_q <= chunk_count_d;
      frame_error_q <= frame_error_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    chunk_count_d = chunk_count_q;
    frame_error_d = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (is_final && llr_bus.llr_in_last) begin
            state_d       = S_VALID;
            chunk_count_d = '0;
          end else if (!is_final && !llr_bus.llr_in_last) begin
            chunk_count_d = chunk_count_q + CW'(1);
          end else begin
            // Length/last disagreement: drop the frame and restart at
            // slot 0. Stale slots are simply overwritten by the next frame.
            frame_error_d = 1'b1;
            chunk_count_d = '0;
          end
        end
      end

      S_VALID: begin
        // A done arriving during the valid cycle releases the frame at once.
        state_d = decoder_done ? S_LOAD : S_HOLD;
      end

      S_HOLD: begin
        if (decoder_done) begin
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d       = S_LOAD;
        chunk_count_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame storage: a chunk lands in its slot whenever it is accepted, even
  // on a mismatch, so the register only changes on accepted chunks.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < NCH; k++) begin
        if (chunk_count_q == CW'(k)) begin
          frame_q[k*W +: W] <= llr_bus.llr_in;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign llr_bus.llr_in_ready  = ready;
  assign channel_register_data = frame_q;
  assign data_valid            = (state_q == S_VALID);
  assign frame_error           = frame_error_q;
  assign chunk_count           = chunk_count_q;

endmodule
`default_nettype wire
